ad_ip_jesd204_tpl_adc_frame_align: RTL and testbench

- Generalised frame aligner for the JESD204 TPL ADC receive path. Sits between the link layer output and the TPL ADC core.
- Uses the link start-of-frame (SOF) vector to byte-shift every lane so that output octet 0 of the first aligned beat is a frame start. This supports frame sizes (F) that do not divide the beat width.
- Tracks the expected SOF pattern beat by beat, flags misalignment, relocks automatically and keeps a saturating error count for the regmap.

---
 rtl/ad_ip_jesd204_tpl_adc_frame_align_pkg.sv | 39 +++
 rtl/ad_ip_jesd204_tpl_adc_frame_align_lane_shift.sv | 37 +++
 rtl/ad_ip_jesd204_tpl_adc_frame_align.sv | 110 +++++++++++
 tb/tb_ad_ip_jesd204_tpl_adc_frame_align.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ad_ip_jesd204_tpl_adc_frame_align_pkg.sv
// Shared types and modulo-F helpers for the JESD204 TPL ADC frame aligner.
package ad_ip_jesd204_tpl_adc_frame_align_pkg;

    typedef enum logic {
        UNLOCKED = 1'b0,
        LOCKED   = 1'b1
    } align_state_e;

    localparam int MAX_OCTETS = 8;

    // Conditional-subtract wrap; inputs never exceed f-1+MAX_OCTETS.
    function automatic int pos_mod(input int val, input int f);
        int r;
        r = val;
        for (int k = 0; k < 2*MAX_OCTETS; k++) begin
            if (r >= f) r = r - f;
        end
        return r;
    endfunction

    function automatic int next_pos(input int pos, input int opb, input int f);
        return pos_mod(pos + opb, f);
    endfunction

    // Bit i set when octet i of a beat starting at frame position pos is a frame start.
    function automatic logic [MAX_OCTETS-1:0] sof_pattern(input int pos, input int opb, input int f);
        logic [MAX_OCTETS-1:0] pat;
        int p;
        pat = '0;
        p = pos;
        for (int i = 0; i < MAX_OCTETS; i++) begin
            if (i < opb) pat[i] = (p == 0);
            p = p + 1;
            if (p >= f) p = 0;
        end
        return pat;
    endfunction

endpackage

// File: rtl/ad_ip_jesd204_tpl_adc_frame_align_lane_shift.sv
// Per-lane one-beat history plus octet window mux selected by the frame offset.
module ad_ip_jesd204_tpl_adc_lane_shift
    import ad_ip_jesd204_tpl_adc_frame_align_pkg::*;
#(
    parameter int OCTETS_PER_BEAT = 4,
    parameter int OFF_W           = 2
) (
    input  logic                         clk,
    input  logic                         resetn,
    input  logic                         load,
    input  logic [OFF_W-1:0]             offset,
    input  logic [8*OCTETS_PER_BEAT-1:0] cur,
    output logic [8*OCTETS_PER_BEAT-1:0] shifted
);

    logic [8*OCTETS_PER_BEAT-1:0]       prev;
    logic [2*OCTETS_PER_BEAT-1:0][7:0]  win;
    logic [OFF_W:0]                     idx;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) prev <= '0;
        else if (load) prev <= cur;
    end

    // Window of two beats: octet offset of prev lands on output octet 0.
    assign win = {cur, prev};

    always_comb begin
        shifted = '0;
        idx     = '0;
        for (int j = 0; j < OCTETS_PER_BEAT; j++) begin
            idx = (OFF_W+1)'(j) + {1'b0, offset};
            shifted[j*8 +: 8] = win[idx];
        end
    end

endmodule

// File: rtl/ad_ip_jesd204_tpl_adc_frame_align.sv
// JESD204 TPL ADC frame aligner: locks on link SOF, byte-shifts lanes, tracks and counts misalignment.
module ad_ip_jesd204_tpl_adc_frame_align
    import ad_ip_jesd204_tpl_adc_frame_align_pkg::*;
#(
    parameter int NUM_LANES        = 1,
    parameter int OCTETS_PER_BEAT  = 4,
    parameter int OCTETS_PER_FRAME = 2,
    parameter int ERR_CNT_WIDTH    = 8
) (
    input  logic                                   clk,
    input  logic                                   resetn,
    input  logic                                   link_valid,
    input  logic [OCTETS_PER_BEAT-1:0]             link_sof,
    input  logic [NUM_LANES*8*OCTETS_PER_BEAT-1:0] link_data,
    output logic                                   link_ready,
    input  logic                                   cfg_realign,
    output logic                                   out_valid,
    output logic [OCTETS_PER_BEAT-1:0]             out_sof,
    output logic [NUM_LANES*8*OCTETS_PER_BEAT-1:0] out_data,
    output logic                                   status_locked,
    output logic                                   status_err,
    output logic [ERR_CNT_WIDTH-1:0]               status_err_cnt
);

    localparam int OPB    = OCTETS_PER_BEAT;
    localparam int F      = OCTETS_PER_FRAME;
    localparam int LANE_W = 8*OPB;
    localparam int POS_W  = (F > 1) ? $clog2(F) : 1;
    localparam int OFF_W  = $clog2(OPB);

    align_state_e                  state;
    logic [OFF_W-1:0]              offset;
    logic [OFF_W-1:0]              sof_idx;
    logic [POS_W-1:0]              in_pos;
    logic [POS_W-1:0]              out_pos;
    logic [OPB-1:0]                expected;
    logic                          sof_match;
    logic [NUM_LANES*LANE_W-1:0]   shifted;

    for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
        ad_ip_jesd204_tpl_adc_lane_shift #(
            .OCTETS_PER_BEAT (OPB),
            .OFF_W           (OFF_W)
        ) i_shift (
            .clk     (clk),
            .resetn  (resetn),
            .load    (link_valid),
            .offset  (offset),
            .cur     (link_data[l*LANE_W +: LANE_W]),
            .shifted (shifted[l*LANE_W +: LANE_W])
        );
    end

    always_comb begin
        sof_idx = '0;
        for (int i = OPB-1; i >= 0; i--) begin
            if (link_sof[i]) sof_idx = OFF_W'(i);
        end
    end

    assign expected      = OPB'(sof_pattern(int'(in_pos), OPB, F));
    assign sof_match     = (state == LOCKED) && (link_sof == expected);
    assign status_locked = (state == LOCKED);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state          <= UNLOCKED;
            offset         <= '0;
            in_pos         <= '0;
            out_pos        <= '0;
            link_ready     <= 1'b0;
            out_valid      <= 1'b0;
            out_sof        <= '0;
            out_data       <= '0;
            status_err     <= 1'b0;
            status_err_cnt <= '0;
        end else begin
            link_ready <= 1'b1;
            out_valid  <= 1'b0;
            status_err <= 1'b0;
            if (cfg_realign) begin
                state <= UNLOCKED;
            end else if (link_valid) begin
                if (sof_match) begin
                    in_pos    <= POS_W'(next_pos(int'(in_pos), OPB, F));
                    out_pos   <= POS_W'(next_pos(int'(out_pos), OPB, F));
                    out_sof   <= OPB'(sof_pattern(int'(out_pos), OPB, F));
                    out_data  <= shifted;
                    out_valid <= 1'b1;
                end else begin
                    if (state == LOCKED) begin
                        status_err <= 1'b1;
                        if (status_err_cnt != '1)
                            status_err_cnt <= status_err_cnt + ERR_CNT_WIDTH'(1);
                    end
                    // The offending beat doubles as a lock candidate, so relock costs no extra beat.
                    if (link_sof != '0) begin
                        state   <= LOCKED;
                        offset  <= sof_idx;
                        in_pos  <= POS_W'(pos_mod(OPB - int'(sof_idx), F));
                        out_pos <= '0;
                    end else begin
                        state <= UNLOCKED;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_ad_ip_jesd204_tpl_adc_frame_align.sv
// Self-checking bench: three aligners (F=2,3,4) on shared data, checked against a frame-position model.
module tb_ad_ip_jesd204_tpl_adc_frame_align;

    localparam int NL  = 2;
    localparam int OPB = 4;
    localparam int DW  = NL*8*OPB;
    localparam int ND  = 3;

    logic                      clk = 1'b0;
    logic                      resetn;
    logic                      link_valid;
    logic                      cfg_realign;
    logic [DW-1:0]             link_data;
    logic [ND-1:0][OPB-1:0]    link_sof;
    logic [ND-1:0]             link_ready, out_valid, status_locked, status_err;
    logic [ND-1:0][OPB-1:0]    out_sof;
    logic [ND-1:0][DW-1:0]     out_data;
    logic [ND-1:0][7:0]        err_cnt;

    for (genvar d = 0; d < ND; d++) begin : g_dut
        ad_ip_jesd204_tpl_adc_frame_align #(
            .NUM_LANES        (NL),
            .OCTETS_PER_BEAT  (OPB),
            .OCTETS_PER_FRAME (d+2),
            .ERR_CNT_WIDTH    (8)
        ) u_dut (
            .clk            (clk),
            .resetn         (resetn),
            .link_valid     (link_valid),
            .link_sof       (link_sof[d]),
            .link_data      (link_data),
            .link_ready     (link_ready[d]),
            .cfg_realign    (cfg_realign),
            .out_valid      (out_valid[d]),
            .out_sof        (out_sof[d]),
            .out_data       (out_data[d]),
            .status_locked  (status_locked[d]),
            .status_err     (status_err[d]),
            .status_err_cnt (err_cnt[d])
        );
    end

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Model state: every accepted beat b carries global octets b*OPB.. ; lock base is the
    // global octet index of a frame start, so frame position of octet g is (g-base) mod F.
    int               gb;
    bit               m_lock [ND];
    int               m_base [ND];
    int               m_cnt  [ND];
    bit               e_valid[ND];
    bit               e_err  [ND];
    logic [OPB-1:0]   e_sof  [ND];
    logic [DW-1:0]    e_data [ND];

    task automatic chk(input string name, input int d, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s (F=%0d) t=%0t: got %0h expected %0h", name, d+2, $time, act, exp);
        end
    endtask

    function automatic logic [7:0] oct(input int l, input int g);
        return 8'((g + 64*l) & 255);
    endfunction

    function automatic logic [DW-1:0] octets_from(input int g0);
        logic [DW-1:0] r;
        for (int l = 0; l < NL; l++)
            for (int j = 0; j < OPB; j++)
                r[(l*OPB+j)*8 +: 8] = oct(l, g0 + j);
        return r;
    endfunction

    function automatic logic [OPB-1:0] frame_marks(input int g, input int base, input int f);
        logic [OPB-1:0] m;
        for (int i = 0; i < OPB; i++) m[i] = (((g + i - base + 1024*f) % f) == 0);
        return m;
    endfunction

    function automatic int lowest(input logic [OPB-1:0] s);
        for (int i = 0; i < OPB; i++) if (s[i]) return i;
        return 0;
    endfunction

    task automatic model_step(input bit v, input logic [ND-1:0][OPB-1:0] s, input bit rl);
        int g, f, start;
        for (int d = 0; d < ND; d++) begin
            e_valid[d] = 1'b0;
            e_err[d]   = 1'b0;
            f = d + 2;
            g = gb*OPB;
            if (rl) begin
                m_lock[d] = 1'b0;
            end else if (v) begin
                if (m_lock[d] && s[d] == frame_marks(g, m_base[d], f)) begin
                    start      = (gb-1)*OPB + (m_base[d] % OPB);
                    e_valid[d] = 1'b1;
                    e_data[d]  = octets_from(start);
                    e_sof[d]   = frame_marks(start, m_base[d], f);
                end else begin
                    if (m_lock[d]) begin
                        e_err[d] = 1'b1;
                        if (m_cnt[d] < 255) m_cnt[d]++;
                        m_lock[d] = 1'b0;
                    end
                    if (s[d] != '0) begin
                        m_lock[d] = 1'b1;
                        m_base[d] = g + lowest(s[d]);
                    end
                end
            end
        end
        if (v && !rl) gb++;
    endtask

    task automatic cyc(input bit v, input logic [ND-1:0][OPB-1:0] s, input bit rl);
        link_valid  = v;
        cfg_realign = rl;
        link_sof    = s;
        link_data   = v ? octets_from(gb*OPB) : {$urandom, $urandom};
        model_step(v, s, rl);
        @(posedge clk);
        #1;
        for (int d = 0; d < ND; d++) begin
            chk("out_valid", d, 64'(out_valid[d]), 64'(e_valid[d]));
            chk("status_err", d, 64'(status_err[d]), 64'(e_err[d]));
            chk("err_cnt", d, 64'(err_cnt[d]), 64'(m_cnt[d]));
            chk("locked", d, 64'(status_locked[d]), 64'(m_lock[d]));
            if (e_valid[d]) begin
                chk("out_data", d, 64'(out_data[d]), 64'(e_data[d]));
                chk("out_sof", d, 64'(out_sof[d]), 64'(e_sof[d]));
            end
        end
    endtask

    task automatic model_reset();
        gb = 0;
        for (int d = 0; d < ND; d++) begin
            m_lock[d] = 1'b0;
            m_base[d] = 0;
            m_cnt[d]  = 0;
        end
    endtask

    task automatic chk_all_zero(input string tag);
        for (int d = 0; d < ND; d++) begin
            chk({tag, " ready"}, d, 64'(link_ready[d]), 64'd0);
            chk({tag, " valid"}, d, 64'(out_valid[d]), 64'd0);
            chk({tag, " sof"}, d, 64'(out_sof[d]), 64'd0);
            chk({tag, " data"}, d, 64'(out_data[d]), 64'd0);
            chk({tag, " locked"}, d, 64'(status_locked[d]), 64'd0);
            chk({tag, " err"}, d, 64'(status_err[d]), 64'd0);
            chk({tag, " cnt"}, d, 64'(err_cnt[d]), 64'd0);
        end
    endtask

    typedef struct {
        bit             v;
        logic [OPB-1:0] sof;
        bit             ev;
        logic [31:0]    ed;
        logic [OPB-1:0] es;
        bit             eerr;
    } vec_t;

    initial begin
        vec_t                    tbl[7];
        int                      td[ND];
        logic [ND-1:0][OPB-1:0]  s;

        // F=4 directed sequence, expected values for lane 0 of the F=4 instance
        tbl[0] = '{1'b1, 4'b0010, 1'b0, 32'h0,        4'b0000, 1'b0};
        tbl[1] = '{1'b1, 4'b0010, 1'b1, 32'h04030201, 4'b0001, 1'b0};
        tbl[2] = '{1'b1, 4'b0010, 1'b1, 32'h08070605, 4'b0001, 1'b0};
        tbl[3] = '{1'b0, 4'b0000, 1'b0, 32'h0,        4'b0000, 1'b0};
        tbl[4] = '{1'b1, 4'b0010, 1'b1, 32'h0c0b0a09, 4'b0001, 1'b0};
        tbl[5] = '{1'b1, 4'b0100, 1'b0, 32'h0,        4'b0000, 1'b1};
        tbl[6] = '{1'b1, 4'b0100, 1'b1, 32'h15141312, 4'b0001, 1'b0};

        resetn = 1'b0; link_valid = 1'b0; cfg_realign = 1'b0;
        link_sof = '0; link_data = '0;
        model_reset();
        #12;
        chk_all_zero("reset");
        @(negedge clk) resetn = 1'b1;
        @(posedge clk); #1;
        for (int d = 0; d < ND; d++) chk("ready after reset", d, 64'(link_ready[d]), 64'd1);

        for (int n = 0; n < 7; n++) begin
            cyc(tbl[n].v, {ND{tbl[n].sof}}, 1'b0);
            chk("tbl valid", 2, 64'(out_valid[2]), 64'(tbl[n].ev));
            chk("tbl err", 2, 64'(status_err[2]), 64'(tbl[n].eerr));
            if (tbl[n].ev) begin
                chk("tbl data", 2, 64'(out_data[2][31:0]), 64'(tbl[n].ed));
                chk("tbl sof", 2, 64'(out_sof[2]), 64'(tbl[n].es));
            end
        end

        // Clean framed streams with random gaps, then occasional single-beat misalignments
        cyc(1'b0, '0, 1'b1);
        for (int d = 0; d < ND; d++) td[d] = $urandom_range(0, d+1);
        for (int n = 0; n < 200; n++) begin
            for (int d = 0; d < ND; d++) begin
                s[d] = frame_marks(gb*OPB, td[d], d+2);
                if (n >= 120 && $urandom_range(0, 29) == 0)
                    s[d] = {s[d][OPB-2:0], s[d][OPB-1]};
            end
            cyc(1'($urandom_range(0, 1)), s, 1'b0);
        end

        // Every beat misaligned: counter must saturate, realign keeps it
        for (int n = 0; n < 300; n++)
            cyc(1'b1, (n % 2 == 0) ? {ND{4'b0001}} : {ND{4'b0010}}, 1'b0);
        for (int d = 0; d < ND; d++) chk("saturated", d, 64'(err_cnt[d]), 64'd255);
        cyc(1'b0, '0, 1'b1);
        for (int d = 0; d < ND; d++) begin
            chk("realign locked", d, 64'(status_locked[d]), 64'd0);
            chk("realign cnt", d, 64'(err_cnt[d]), 64'd255);
        end

        // Asynchronous reset in the middle of a locked stream
        for (int n = 0; n < 6; n++) begin
            for (int d = 0; d < ND; d++) s[d] = frame_marks(gb*OPB, 0, d+2);
            cyc(1'b1, s, 1'b0);
        end
        #3 resetn = 1'b0;
        #1;
        chk_all_zero("async reset");
        model_reset();
        link_valid = 1'b0;
        @(negedge clk) resetn = 1'b1;
        @(posedge clk); #1;
        for (int d = 0; d < ND; d++) chk("ready after reset", d, 64'(link_ready[d]), 64'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
